// File: rtl/riscv_pkg.sv
// riscv_pkg: shared run-controller state encoding and default tohost address.
package riscv_pkg;
    typedef enum logic [1:0] {ST_HOLD, ST_RUN, ST_DONE, ST_TMO} run_state_e;
    localparam logic [31:0] TOHOST_ADDR_DEFAULT = 32'h0000_0FFC;
endpackage

// File: rtl/run_controller_sat_counter.sv
// sat_counter: up-counter with enable and synchronous clear that sticks at all-ones.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] q
);
    logic [W-1:0] q_d, q_q;
    always_comb q_d = clr ? '0 : (en && q_q != '1) ? q_q + W'(1) : q_q;
    always_ff @(posedge clk) q_q <= q_d;
    assign q = q_q;
endmodule

// File: rtl/run_controller.sv
// run_controller: holds the core in reset, runs it, and ends the run on a tohost write or timeout.
module run_controller
    import riscv_pkg::*;
#(
    parameter int              XLEN        = 32,
    parameter int              CNT_W       = 32,
    parameter int              RST_CYCLES  = 2,
    parameter int              TIMEOUT     = 50,
    parameter logic [XLEN-1:0] TOHOST_ADDR = XLEN'(TOHOST_ADDR_DEFAULT)
) (
    input  logic             clk,
    input  logic             rst,
    output logic             core_rst,
    input  logic             instr_valid,
    input  logic             mem_we,
    input  logic [XLEN-1:0]  mem_addr,
    input  logic [XLEN-1:0]  mem_wdata,
    output logic             done,
    output logic             pass,
    output logic [XLEN-1:0]  fail_code,
    output logic             timeout,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instret_cnt
);
    localparam logic [7:0]  HOLD_LAST = 8'(RST_CYCLES - 1);
    // Wide compare so a narrow counter that saturates below TIMEOUT never aliases onto it.
    localparam logic [63:0] TMO_LAST  = 64'(TIMEOUT - 1);
    run_state_e      state_d, state_q;
    logic [7:0]      hold_cnt_d, hold_cnt_q;
    logic            core_rst_d, core_rst_q;
    logic            done_d, done_q, pass_d, pass_q, timeout_d, timeout_q;
    logic [XLEN-1:0] fail_code_d, fail_code_q;
    logic            in_run, hit, tmo_hit;
    always_comb begin
        in_run      = state_q == ST_RUN;
        hit         = in_run && mem_we && mem_addr == TOHOST_ADDR && mem_wdata != '0;
        tmo_hit     = in_run && !hit && 64'(cycle_cnt) == TMO_LAST;
        hold_cnt_d  = state_q == ST_HOLD && hold_cnt_q != HOLD_LAST ? hold_cnt_q + 8'd1 : hold_cnt_q;
        state_d     = state_q == ST_HOLD && hold_cnt_q == HOLD_LAST ? ST_RUN :
                      hit ? ST_DONE : tmo_hit ? ST_TMO : state_q;
        done_d      = done_q | hit;
        pass_d      = hit ? mem_wdata == XLEN'(1) : pass_q;
        fail_code_d = hit ? (mem_wdata == XLEN'(1) ? '0 : mem_wdata >> 1) : fail_code_q;
        timeout_d   = timeout_q | tmo_hit;
        core_rst_d  = state_d != ST_RUN;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_HOLD;
            hold_cnt_q  <= '0;
            core_rst_q  <= 1'b1;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            fail_code_q <= '0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_cnt_q  <= hold_cnt_d;
            core_rst_q  <= core_rst_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            fail_code_q <= fail_code_d;
            timeout_q   <= timeout_d;
        end
    end
    sat_counter #(.W(CNT_W)) u_cycle (
        .clk(clk), .clr(rst), .en(in_run), .q(cycle_cnt)
    );
    sat_counter #(.W(CNT_W)) u_instret (
        .clk(clk), .clr(rst), .en(in_run && instr_valid), .q(instret_cnt)
    );
    assign core_rst  = core_rst_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign fail_code = fail_code_q;
    assign timeout   = timeout_q;
endmodule
